key_input_ctrl: RTL and testbench



---
 rtl/key_input_ctrl_pkg.sv | 29 ++
 rtl/key_channel.sv | 116 +++++++++++
 rtl/key_input_ctrl.sv | 35 +++
 tb/tb_key_input_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/key_input_ctrl_pkg.sv
// Shared definitions for the push-button conditioning path: key indices,
// per-key FSM encoding and default timing at 25 MHz.
package key_input_ctrl_pkg;

  localparam int unsigned KEY_UP    = 0;
  localparam int unsigned KEY_DOWN  = 1;
  localparam int unsigned KEY_LEFT  = 2;
  localparam int unsigned KEY_RIGHT = 3;
  localparam int unsigned NUM_KEYS  = KEY_RIGHT + 1;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 250_000;
  localparam int unsigned DEF_REPEAT_DELAY    = 7_500_000;
  localparam int unsigned DEF_REPEAT_PERIOD   = 2_500_000;
  // Rotate (up) must never auto-repeat.
  localparam logic [NUM_KEYS-1:0] DEF_REPEAT_MASK = ~(NUM_KEYS'(1) << KEY_UP);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2,
    ST_HOLD   = 2'd3
  } key_state_e;

  // Width of a counter that must hold values 0 .. n-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_channel.sv
// One key path: 2-FF synchroniser, debounce counter, then the
// press / auto-repeat FSM with its own timer and a registered pulse output.
module key_channel
  import key_input_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic vga_clk,
  input  logic rst,
  input  logic key_raw,
  output logic op_key,
  output logic key_held
);

  localparam int unsigned DEB_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam int unsigned TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned TMR_W   = cnt_width(TMR_MAX);

  localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD - 1);
  localparam logic             RELEASED    = ACTIVE_LOW;

  logic [1:0]       sync_q, sync_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             held_q, held_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  key_state_e       state_q, state_d;
  logic             pulse_q, pulse_d;
  logic             key_level;

  // State register. NOTE: sequential state uses non-blocking assignments only;
  // the synchroniser resets to the released pin level so reset never looks
  // like a press.
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      sync_q    <= {2{RELEASED}};
      deb_cnt_q <= '0;
      held_q    <= 1'b0;
      tmr_q     <= '0;
      state_q   <= ST_IDLE;
      pulse_q   <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      deb_cnt_q <= deb_cnt_d;
      held_q    <= held_d;
      tmr_q     <= tmr_d;
      state_q   <= state_d;
      pulse_q   <= pulse_d;
    end
  end

  assign sync_d    = {sync_q[0], key_raw};
  assign key_level = sync_q[1] ^ ACTIVE_LOW;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    held_d    = held_q;
    deb_cnt_d = '0;
    if (key_level != held_q) begin
      if (deb_cnt_q == DEB_LAST) held_d = key_level;
      else                       deb_cnt_d = deb_cnt_q + 1'b1;
    end
  end

  // Next state. A released key overrides everything, including a timer expiry.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    if (!held_q) begin
      state_d = ST_IDLE;
      tmr_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = REPEAT_EN ? ST_DELAY : ST_HOLD;
          tmr_d   = '0;
        end
        ST_DELAY: begin
          if (tmr_q == DELAY_LAST) begin
            state_d = ST_REPEAT;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        ST_REPEAT: begin
          if (tmr_q == PERIOD_LAST) tmr_d = '0;
          else                      tmr_d = tmr_q + 1'b1;
        end
        default: tmr_d = '0;
      endcase
    end
  end

  // Pulse decode. held_q=1 while IDLE can only mean a fresh press.
  always_comb begin
    pulse_d = 1'b0;
    if (held_q) begin
      unique case (state_q)
        ST_IDLE:   pulse_d = 1'b1;
        ST_DELAY:  pulse_d = (tmr_q == DELAY_LAST);
        ST_REPEAT: pulse_d = (tmr_q == PERIOD_LAST);
        default:   pulse_d = 1'b0;
      endcase
    end
  end

  assign op_key   = pulse_q;
  assign key_held = held_q;

endmodule

// File: rtl/key_input_ctrl.sv
// Conditions the four raw push-buttons into one-cycle operation pulses for the
// grid controller; one independent key_channel per button.
module key_input_ctrl
  import key_input_ctrl_pkg::*;
#(
  parameter int unsigned          DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned          REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned          REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter logic [NUM_KEYS-1:0]  REPEAT_MASK     = DEF_REPEAT_MASK,
  parameter bit                   ACTIVE_LOW      = 1'b1
) (
  input  logic                vga_clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] op_keys,
  output logic [NUM_KEYS-1:0] key_held
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .REPEAT_EN       (REPEAT_MASK[i]),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_key (
      .vga_clk  (vga_clk),
      .rst      (rst),
      .key_raw  (key_raw[i]),
      .op_key   (op_keys[i]),
      .key_held (key_held[i])
    );
  end

endmodule

// File: tb/tb_key_input_ctrl.sv
// Table-driven bench for key_input_ctrl with short timing constants; expected
// pulses are queued per scenario and popped as cycles are observed.
module tb_key_input_ctrl;
  import key_input_ctrl_pkg::*;

  localparam int unsigned DEB = 4;
  localparam int unsigned RD  = 10;
  localparam int unsigned RP  = 5;

  logic       vga_clk = 1'b0;
  logic       rst     = 1'b1;
  logic [3:0] key_raw = '0;
  logic [3:0] op_keys;
  logic [3:0] key_held;

  key_input_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP),
    .REPEAT_MASK     (4'b1110),
    .ACTIVE_LOW      (1'b0)
  ) dut (
    .vga_clk  (vga_clk),
    .rst      (rst),
    .key_raw  (key_raw),
    .op_keys  (op_keys),
    .key_held (key_held)
  );

  always #20 vga_clk = ~vga_clk;

  // Cycle c is the clock period after edge c; raw keys change early in the period.
  typedef struct {
    string      name;
    logic [3:0] keys;
    int         on_len;
    int         period;
    int         reps;
    int         rst_at;
    int         run_len;
    logic [3:0] pulse_val;
    int         pulses[8];
    int         held[4];
  } vec_t;

  typedef struct {
    int         cyc;
    logic [3:0] val;
  } exp_ev_t;

  vec_t    vecs[7];
  exp_ev_t sb[$];
  int      total = 0;
  int      bad   = 0;
  int      cur_cyc = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cur_cyc, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input logic [3:0] keys, input int on_len,
                              input int period, input int reps, input int rst_at, input int run_len);
    vec_t v;
    v.name = name; v.keys = keys; v.on_len = on_len; v.period = period; v.reps = reps;
    v.rst_at = rst_at; v.run_len = run_len; v.pulse_val = keys;
    v.pulses = '{-1, -1, -1, -1, -1, -1, -1, -1};
    v.held   = '{-1, -1, -1, -1};
    return v;
  endfunction

  function automatic logic [3:0] raw_at(input vec_t v, input int c);
    if (c < v.reps * v.period && (c % v.period) < v.on_len) return v.keys;
    return 4'b0000;
  endfunction

  function automatic logic [3:0] held_at(input vec_t v, input int c);
    if ((c >= v.held[0] && c < v.held[1]) || (c >= v.held[2] && c < v.held[3])) return v.keys;
    return 4'b0000;
  endfunction

  task automatic apply_reset();
    key_raw = '0;
    rst     = 1'b1;
    repeat (2) @(posedge vga_clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    exp_ev_t    e;
    logic [3:0] exp_op;
    sb.delete();
    for (int k = 0; k < 8; k++) begin
      if (v.pulses[k] >= 0) begin
        e.cyc = v.pulses[k];
        e.val = v.pulse_val;
        sb.push_back(e);
      end
    end
    apply_reset();
    for (int c = 0; c < v.run_len; c++) begin
      if (c > 0) begin
        @(posedge vga_clk);
        #1;
      end
      key_raw = raw_at(v, c);
      rst     = (c == v.rst_at);
      @(negedge vga_clk);
      cur_cyc = c;
      exp_op  = 4'b0000;
      if (sb.size() > 0 && sb[0].cyc == c) begin
        exp_op = sb[0].val;
        void'(sb.pop_front());
      end
      check({v.name, "/op_keys"}, 32'(op_keys), 32'(exp_op));
      check({v.name, "/key_held"}, 32'(key_held), 32'(held_at(v, c)));
    end
    check({v.name, "/pulses_left"}, 32'(sb.size()), 32'd0);
    @(posedge vga_clk);
    #1;
    rst     = 1'b0;
    key_raw = '0;
  endtask

  initial begin
    vecs[0] = mk("repeat_left", 4'b0100, 40, 60, 1, -1, 60);
    vecs[0].pulses = '{7, 17, 22, 27, 32, 37, 42, -1};
    vecs[0].held   = '{6, 46, -1, -1};

    vecs[1] = mk("up_no_repeat", 4'b0001, 40, 60, 1, -1, 60);
    vecs[1].pulses = '{7, -1, -1, -1, -1, -1, -1, -1};
    vecs[1].held   = '{6, 46, -1, -1};

    vecs[2] = mk("glitch_down", 4'b0010, 3, 6, 6, -1, 45);

    vecs[3] = mk("two_keys", 4'b1100, 12, 40, 1, -1, 30);
    vecs[3].pulses = '{7, 17, -1, -1, -1, -1, -1, -1};
    vecs[3].held   = '{6, 18, -1, -1};

    // Reset lands on the cycle a repeat pulse was due; the press restarts cleanly.
    vecs[4] = mk("reset_in_repeat", 4'b1000, 100, 100, 1, 21, 36);
    vecs[4].pulses = '{7, 17, 29, -1, -1, -1, -1, -1};
    vecs[4].held   = '{6, 22, 28, 36};

    // key_held falls on cycle 41 exactly when the repeat timer expires.
    vecs[5] = mk("release_on_expiry", 4'b0010, 35, 60, 2, -1, 80);
    vecs[5].pulses = '{7, 17, 22, 27, 32, 37, 67, 77};
    vecs[5].held   = '{6, 41, 66, 80};

    vecs[6] = mk("debounce_edge", 4'b0001, 4, 40, 1, -1, 20);
    vecs[6].pulses = '{7, -1, -1, -1, -1, -1, -1, -1};
    vecs[6].held   = '{6, 10, -1, -1};

    rst     = 1'b1;
    key_raw = 4'b1111;
    repeat (3) @(posedge vga_clk);
    #1;
    check("reset/op_keys", 32'(op_keys), 32'd0);
    check("reset/key_held", 32'(key_held), 32'd0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
